// File: rtl/pc_stack_sequencer_if.sv
// Control/status bundle between the sequencing state machine (master)
// and the program counter with return-address stack (slave).
interface pc_stack_sequencer_if #(
    parameter int ADDR_W      = 7,
    parameter int OFF_W       = 5,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic              Up;
    logic              Load;
    logic [ADDR_W-1:0] Load_addr;
    logic              Branch;
    logic [OFF_W-1:0]  Offset;
    logic              Call;
    logic              Ret;
    logic              Halt;
    logic              Resume;

    logic [ADDR_W-1:0]  mem_addr;
    logic               halted;
    logic               wrap;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;
    logic               stk_err;

    modport master (
        output Up, Load, Load_addr, Branch, Offset, Call, Ret, Halt, Resume,
        input  mem_addr, halted, wrap, stk_depth, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  Up, Load, Load_addr, Branch, Offset, Call, Ret, Halt, Resume,
        output mem_addr, halted, wrap, stk_depth, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/pc_stack_sequencer.sv
// Program counter for the instruction-memory address path: count-up,
// absolute jump, signed relative branch, call/return via a small LIFO,
// halt/resume, plus wrap pulse and sticky stack-fault status.
module pc_stack_sequencer #(
    parameter int          ADDR_W      = 7,
    parameter int          OFF_W       = 5,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                      Clk,
    input  logic                      Clr_n,
    pc_stack_sequencer_if.slave       bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               wrap_q, wrap_d;
    logic               push_en;

    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  addr_plus1;
    logic [ADDR_W:0]    br_sum;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic               stack_full;
    logic               stack_empty;

    assign addr_plus1  = addr_q + ADDR_W'(1);
    // One extra bit: set exactly when the signed branch leaves [0, 2^ADDR_W-1]
    // in either direction, since |Offset| < 2^ADDR_W.
    assign br_sum      = {1'b0, addr_q}
                       + {{(ADDR_W + 1 - OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};
    assign top_idx     = IDX_W'(depth_q - DEPTH_W'(1));
    assign push_idx    = IDX_W'(depth_q);
    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);

    // Run-state register plus address, depth, fault and wrap registers.
    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state_q <= RUN;
            addr_q  <= ADDR_W'(RESET_ADDR);
            depth_q <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    // Return-address storage; contents past the current depth are don't-care.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            stack_q[push_idx] <= addr_plus1;
        end
    end

    // Next-state decode: one address op per running cycle, Ret > Call > Load > Branch > Up.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        push_en = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.Halt) begin
                    state_d = HALTED;
                end else if (bus.Ret) begin
                    if (!stack_empty) begin
                        addr_d  = stack_q[top_idx];
                        depth_d = depth_q - DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.Call) begin
                    if (!stack_full) begin
                        push_en = 1'b1;
                        addr_d  = bus.Load_addr;
                        depth_d = depth_q + DEPTH_W'(1);
                        wrap_d  = (addr_q == '1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.Load) begin
                    addr_d = bus.Load_addr;
                end else if (bus.Branch) begin
                    addr_d = br_sum[ADDR_W-1:0];
                    wrap_d = br_sum[ADDR_W];
                end else if (bus.Up) begin
                    addr_d = addr_plus1;
                    wrap_d = (addr_q == '1);
                end
            end
            HALTED: begin
                if (bus.Resume && !bus.Halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.halted    = (state_q == HALTED);
    assign bus.wrap      = wrap_q;
    assign bus.stk_depth = depth_q;
    assign bus.stk_full  = stack_full;
    assign bus.stk_empty = stack_empty;
    assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Scoreboard bench: the driver updates an arithmetic/queue reference model and
// queues the expected post-edge outputs; a monitor compares after each edge.
module tb_pc_stack_sequencer;
    localparam int AW    = 7;
    localparam int OW    = 5;
    localparam int DEPTH = 4;
    localparam int SPAN  = 1 << AW;

    logic Clk;
    logic Clr_n;

    pc_stack_sequencer_if #(.ADDR_W(AW), .OFF_W(OW), .STACK_DEPTH(DEPTH)) bus ();

    pc_stack_sequencer #(
        .ADDR_W(AW), .OFF_W(OW), .STACK_DEPTH(DEPTH), .RESET_ADDR(0)
    ) dut (
        .Clk  (Clk),
        .Clr_n(Clr_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int addr;
        bit halted;
        bit wrap;
        int depth;
        bit full;
        bit empty;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_addr   = 0;
    bit m_halted = 0;
    bit m_wrap   = 0;
    bit m_err    = 0;
    int m_stk[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mem_addr",  int'(bus.mem_addr),  e.addr);
                check("halted",    int'(bus.halted),    int'(e.halted));
                check("wrap",      int'(bus.wrap),      int'(e.wrap));
                check("stk_depth", int'(bus.stk_depth), e.depth);
                check("stk_full",  int'(bus.stk_full),  int'(e.full));
                check("stk_empty", int'(bus.stk_empty), int'(e.empty));
                check("stk_err",   int'(bus.stk_err),   int'(e.err));
            end
        end
    end

    function automatic int wrap_addr(input int v);
        return ((v % SPAN) + SPAN) % SPAN;
    endfunction

    task automatic model_step();
        int n;
        m_wrap = 0;
        if (!Clr_n) begin
            m_addr   = 0;
            m_halted = 0;
            m_err    = 0;
            m_stk.delete();
        end else if (m_halted) begin
            if (bus.Resume && !bus.Halt) m_halted = 0;
        end else if (bus.Halt) begin
            m_halted = 1;
        end else if (bus.Ret) begin
            if (m_stk.size() > 0) m_addr = m_stk.pop_back();
            else m_err = 1;
        end else if (bus.Call) begin
            if (m_stk.size() < DEPTH) begin
                n = m_addr + 1;
                m_wrap = (n >= SPAN);
                m_stk.push_back(wrap_addr(n));
                m_addr = int'(bus.Load_addr);
            end else begin
                m_err = 1;
            end
        end else if (bus.Load) begin
            m_addr = int'(bus.Load_addr);
        end else if (bus.Branch || bus.Up) begin
            n = bus.Branch ? m_addr + int'($signed(bus.Offset)) : m_addr + 1;
            m_wrap = (n < 0) || (n >= SPAN);
            m_addr = wrap_addr(n);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.addr   = m_addr;
        e.halted = m_halted;
        e.wrap   = m_wrap;
        e.depth  = m_stk.size();
        e.full   = (m_stk.size() == DEPTH);
        e.empty  = (m_stk.size() == 0);
        e.err    = m_err;
        exp_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle();
        Clr_n         = 1'b1;
        bus.Up        = 1'b0;
        bus.Load      = 1'b0;
        bus.Load_addr = '0;
        bus.Branch    = 1'b0;
        bus.Offset    = '0;
        bus.Call      = 1'b0;
        bus.Ret       = 1'b0;
        bus.Halt      = 1'b0;
        bus.Resume    = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        idle(); Clr_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        idle();
    endtask

    task automatic do_load(input int a);
        idle(); bus.Load = 1'b1; bus.Load_addr = AW'(a); tick(); idle();
    endtask

    task automatic do_up(input int cycles);
        idle(); bus.Up = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        idle();
    endtask

    task automatic do_branch(input int off);
        idle(); bus.Branch = 1'b1; bus.Offset = OW'(off); tick(); idle();
    endtask

    task automatic do_call(input int a);
        idle(); bus.Call = 1'b1; bus.Load_addr = AW'(a); tick(); idle();
    endtask

    task automatic do_ret();
        idle(); bus.Ret = 1'b1; tick(); idle();
    endtask

    initial begin
        idle();
        do_reset(2);

        // Count-up without wrap, then wrap at max
        do_up(20);
        do_load(127);
        do_up(2);

        // Relative branches, backwards across zero and forwards
        do_load(0);
        do_branch(-3);
        do_load(10);
        do_branch(5);

        // Call / Up / Ret round trip
        do_load(10);
        do_call(40);
        do_up(3);
        do_ret();

        // Overflow then drain in reverse order, then underflow
        do_reset(1);
        for (int i = 0; i < 5; i++) do_call(10 * (i + 1));
        for (int i = 0; i < 5; i++) do_ret();

        // Underflow from a clean state; fault stays sticky
        do_reset(1);
        do_ret();
        do_up(3);

        // Call from max pushes a wrapped return address
        do_load(127);
        do_call(3);
        do_ret();

        // Halt ignores address and stack inputs until Resume
        do_reset(1);
        do_load(7);
        idle(); bus.Halt = 1'b1; tick(); idle();
        for (int i = 0; i < 10; i++) begin
            bus.Up = 1'b1; bus.Load = i[0]; bus.Call = i[1];
            bus.Load_addr = AW'($urandom_range(0, SPAN - 1));
            tick();
        end
        idle(); bus.Resume = 1'b1; bus.Halt = 1'b1; tick();
        idle(); bus.Resume = 1'b1; tick();
        do_up(1);

        // Reset dominates a Call with two entries already stacked
        do_call(50);
        do_call(60);
        idle(); Clr_n = 1'b0; bus.Call = 1'b1; bus.Load_addr = AW'(99); tick();
        idle(); tick();

        // Randomised mix
        for (int i = 0; i < 400; i++) begin
            Clr_n         = ($urandom_range(0, 59) != 0);
            bus.Halt      = ($urandom_range(0, 14) == 0);
            bus.Resume    = ($urandom_range(0, 3) == 0);
            bus.Ret       = ($urandom_range(0, 5) == 0);
            bus.Call      = ($urandom_range(0, 5) == 0);
            bus.Load      = ($urandom_range(0, 5) == 0);
            bus.Branch    = ($urandom_range(0, 2) == 0);
            bus.Up        = ($urandom_range(0, 1) == 0);
            bus.Load_addr = AW'($urandom_range(0, SPAN - 1));
            bus.Offset    = OW'($urandom_range(0, (1 << OW) - 1));
            tick();
        end
        idle();
        tick();

        @(posedge Clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
